// File: rtl/systolic_ctrl_if.sv
// Memory bus between the systolic array controller and its tile memory.
// The controller drives address/strobes/write data; the memory returns read data.
interface systolic_ctrl_if #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int RDATA_W = 32
);
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd_en;
    logic               mem_wr_en;
    logic [DATA_W-1:0]  mem_wdata;
    logic [RDATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Tile sequencer for an NxN systolic array: loads weights and inputs,
// feeds row-skewed inputs during compute, then stores the row results.
module systolic_ctrl #(
    parameter int ARRAY_SIZE = 4,
    parameter int INPUT_W    = 8,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  logic                   start,
    input  logic                   clear,
    input  logic [2:0]             op0_precision,
    input  logic [2:0]             op1_precision,
    input  logic [ADDR_W-1:0]      input_base_addr,
    input  logic [ADDR_W-1:0]      weight_base_addr,
    input  logic [ADDR_W-1:0]      output_base_addr,
    systolic_ctrl_if.master        mem,
    input  logic [ARRAY_SIZE-1:0][DATA_W-1:0] psum_in,
    output logic                   weight_load,
    output logic [$clog2(ARRAY_SIZE)-1:0] weight_row,
    output logic [ARRAY_SIZE*INPUT_W-1:0] weight_data,
    output logic [ARRAY_SIZE-1:0][INPUT_W-1:0] input_forward,
    output logic                   compute_en,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             input_precision,
    output logic [2:0]             output_precision
);
    localparam int N     = ARRAY_SIZE;
    localparam int RW    = $clog2(N);
    localparam int CNT_W = $clog2(3 * N);

    localparam logic [CNT_W-1:0] LAST_N = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(3 * N - 3);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LD_WEIGHT,
        LD_INPUT,
        COMPUTE,
        ST_OUTPUT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    row_idx;
    logic [INPUT_W-1:0] ibuf [N][N];

    assign row_idx = RW'(cnt_q);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ibuf[r][k] holds element r of input word k
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            input_precision  <= '0;
            output_precision <= '0;
            for (int r = 0; r < N; r++)
                for (int k = 0; k < N; k++)
                    ibuf[r][k] <= '0;
        end else begin
            if (state_q == SETUP) begin
                input_precision  <= op0_precision;
                output_precision <= op1_precision;
            end
            if (state_q == LD_INPUT && !clear)
                for (int r = 0; r < N; r++)
                    ibuf[r][row_idx] <=
                        mem.mem_rdata[r*INPUT_W +: INPUT_W];
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 1'b1;
        mem.mem_addr  = '0;
        mem.mem_rd_en = 1'b0;
        mem.mem_wr_en = 1'b0;
        mem.mem_wdata = '0;
        weight_load   = 1'b0;
        weight_row    = '0;
        weight_data   = '0;
        input_forward = '0;
        compute_en    = 1'b0;
        busy          = (state_q != IDLE);
        done          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = SETUP;
            end
            SETUP: begin
                state_d = LD_WEIGHT;
            end
            LD_WEIGHT: begin
                mem.mem_rd_en = 1'b1;
                mem.mem_addr  = weight_base_addr + ADDR_W'(cnt_q);
                weight_load   = 1'b1;
                weight_row    = row_idx;
                weight_data   = mem.mem_rdata;
                if (cnt_q == LAST_N) state_d = LD_INPUT;
            end
            LD_INPUT: begin
                mem.mem_rd_en = 1'b1;
                mem.mem_addr  = input_base_addr + ADDR_W'(cnt_q);
                if (cnt_q == LAST_N) state_d = COMPUTE;
            end
            COMPUTE: begin
                compute_en = 1'b1;
                // row r sees word t-r, i.e. a diagonal wavefront
                for (int r = 0; r < N; r++)
                    for (int k = 0; k < N; k++)
                        if (32'(cnt_q) == r + k)
                            input_forward[r] = ibuf[r][k];
                if (cnt_q == LAST_C) state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                mem.mem_wr_en = 1'b1;
                mem.mem_addr  = output_base_addr + ADDR_W'(cnt_q);
                mem.mem_wdata = psum_in[row_idx];
                if (cnt_q == LAST_N) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clear) state_d = IDLE;
        if (state_d != state_q || state_q == IDLE) cnt_d = '0;
    end
endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: timeline model for N=4 checked every cycle,
// literal pins for skew/wrap/abort, and N=2/N=8 tile-length sweeps.
module tb_systolic_ctrl;
    localparam int N = 4;

    logic clk = 1'b0;
    logic nRST = 1'b0;
    logic start = 1'b0;
    logic clear = 1'b0;
    logic start_sw = 1'b0;
    logic [2:0] op0 = 3'd5;
    logic [2:0] op1 = 3'd2;
    logic [9:0] wb = 10'h100;
    logic [9:0] ib = 10'h200;
    logic [9:0] ob = 10'h300;

    always #5 clk = ~clk;

    logic [31:0] rom [1024];
    logic [N-1:0][31:0] psum4;

    systolic_ctrl_if #(.ADDR_W(10), .DATA_W(32), .RDATA_W(32)) if4 ();
    assign if4.mem_rdata = if4.mem_rd_en ? rom[if4.mem_addr] : '0;

    logic       wl4, ce4, busy4, done4;
    logic [1:0] wrow4;
    logic [31:0] wd4;
    logic [N-1:0][7:0] fwd4;
    logic [2:0] ip4, opr4;

    systolic_ctrl #(.ARRAY_SIZE(4)) u4 (
        .clk(clk), .nRST(nRST), .start(start), .clear(clear),
        .op0_precision(op0), .op1_precision(op1),
        .input_base_addr(ib), .weight_base_addr(wb),
        .output_base_addr(ob), .mem(if4), .psum_in(psum4),
        .weight_load(wl4), .weight_row(wrow4),
        .weight_data(wd4), .input_forward(fwd4),
        .compute_en(ce4), .busy(busy4), .done(done4),
        .input_precision(ip4), .output_precision(opr4)
    );

    systolic_ctrl_if #(.ADDR_W(10), .DATA_W(32), .RDATA_W(16)) if2 ();
    assign if2.mem_rdata = if2.mem_rd_en ? 16'hA5C3 : '0;
    logic [1:0][31:0] psum2;
    logic       wl2, ce2, busy2, done2;
    logic [0:0] wrow2;
    logic [15:0] wd2;
    logic [1:0][7:0] fwd2;
    logic [2:0] ip2, opr2;

    systolic_ctrl #(.ARRAY_SIZE(2)) u2 (
        .clk(clk), .nRST(nRST), .start(start_sw), .clear(1'b0),
        .op0_precision(op0), .op1_precision(op1),
        .input_base_addr(ib), .weight_base_addr(wb),
        .output_base_addr(ob), .mem(if2), .psum_in(psum2),
        .weight_load(wl2), .weight_row(wrow2),
        .weight_data(wd2), .input_forward(fwd2),
        .compute_en(ce2), .busy(busy2), .done(done2),
        .input_precision(ip2), .output_precision(opr2)
    );

    systolic_ctrl_if #(.ADDR_W(10), .DATA_W(32), .RDATA_W(64)) if8 ();
    assign if8.mem_rdata = if8.mem_rd_en ? 64'h0102030405060708 : '0;
    logic [7:0][31:0] psum8;
    logic       wl8, ce8, busy8, done8;
    logic [2:0] wrow8;
    logic [63:0] wd8;
    logic [7:0][7:0] fwd8;
    logic [2:0] ip8, opr8;

    systolic_ctrl #(.ARRAY_SIZE(8)) u8 (
        .clk(clk), .nRST(nRST), .start(start_sw), .clear(1'b0),
        .op0_precision(op0), .op1_precision(op1),
        .input_base_addr(ib), .weight_base_addr(wb),
        .output_base_addr(ob), .mem(if8), .psum_in(psum8),
        .weight_load(wl8), .weight_row(wrow8),
        .weight_data(wd8), .input_forward(fwd8),
        .compute_en(ce8), .busy(busy8), .done(done8),
        .input_precision(ip8), .output_precision(opr8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: cyc is the position in the tile timeline (0 = idle,
    // 1 = setup, ..., 6N = done), counted from the start-sampling edge.
    int cyc = 0;
    logic [2:0] e_ip = '0;
    logic [2:0] e_op = '0;

    always @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cyc  <= 0;
            e_ip <= '0;
            e_op <= '0;
        end else begin
            if (cyc == 1) begin
                e_ip <= op0;
                e_op <= op1;
            end
            if (clear) cyc <= 0;
            else if (cyc == 0) cyc <= start ? 1 : 0;
            else if (cyc == 6 * N) cyc <= 0;
            else cyc <= cyc + 1;
        end
    end

    logic [9:0]  e_addr, a_tmp;
    logic        e_rd, e_wr, e_wl, e_ce, e_busy, e_done;
    logic [1:0]  e_wrow;
    logic [31:0] e_wd, e_wdat, w_tmp;
    logic [N-1:0][7:0] e_fwd;

    logic [9:0] addr_log [32];
    logic       ce_log   [32];
    logic       done_log [32];
    logic [7:0] f3_log   [3*N-2];

    always @(negedge clk) begin
        int k;
        e_addr = '0; e_rd = 0; e_wr = 0; e_wl = 0; e_ce = 0;
        e_wrow = '0; e_wd = '0; e_wdat = '0; e_fwd = '0;
        e_busy = (cyc > 0);
        e_done = (cyc == 6 * N);
        if (cyc >= 2 && cyc <= N + 1) begin
            k = cyc - 2;
            e_rd = 1; e_wl = 1;
            e_addr = wb + 10'(k);
            e_wrow = 2'(k);
            e_wd = rom[e_addr];
        end else if (cyc >= N + 2 && cyc <= 2 * N + 1) begin
            k = cyc - N - 2;
            e_rd = 1;
            e_addr = ib + 10'(k);
        end else if (cyc >= 2 * N + 2 && cyc <= 5 * N - 1) begin
            k = cyc - 2 * N - 2;
            e_ce = 1;
            for (int r = 0; r < N; r++)
                if (k >= r && k <= r + N - 1) begin
                    a_tmp = ib + 10'(k - r);
                    w_tmp = rom[a_tmp];
                    e_fwd[r] = w_tmp[8*r +: 8];
                end
        end else if (cyc >= 5 * N && cyc <= 6 * N - 1) begin
            k = cyc - 5 * N;
            e_wr = 1;
            e_addr = ob + 10'(k);
            e_wdat = psum4[k];
        end
        chk("mem_addr", 64'(if4.mem_addr), 64'(e_addr));
        chk("mem_rd_en", 64'(if4.mem_rd_en), 64'(e_rd));
        chk("mem_wr_en", 64'(if4.mem_wr_en), 64'(e_wr));
        chk("mem_wdata", 64'(if4.mem_wdata), 64'(e_wdat));
        chk("weight_load", 64'(wl4), 64'(e_wl));
        chk("weight_row", 64'(wrow4), 64'(e_wrow));
        chk("weight_data", 64'(wd4), 64'(e_wd));
        chk("input_forward", 64'(fwd4), 64'(e_fwd));
        chk("compute_en", 64'(ce4), 64'(e_ce));
        chk("busy", 64'(busy4), 64'(e_busy));
        chk("done", 64'(done4), 64'(e_done));
        chk("input_prec", 64'(ip4), 64'(e_ip));
        chk("output_prec", 64'(opr4), 64'(e_op));
        if (cyc > 0 && cyc < 32) begin
            addr_log[cyc] = if4.mem_addr;
            ce_log[cyc]   = ce4;
            done_log[cyc] = done4;
        end
        if (cyc >= 2 * N + 2 && cyc <= 5 * N - 1)
            f3_log[cyc - 2 * N - 2] = fwd4[3];
    end

    logic sw_go = 1'b0;
    logic ab_go = 1'b0;
    int sw_c = 0, d2_at = 0, d8_at = 0, w2 = 0, w8 = 0;
    int ab_wr = 0, ab_done = 0;

    always @(negedge clk) begin
        if (sw_go) begin
            sw_c++;
            if (done2 && d2_at == 0) d2_at = sw_c;
            if (done8 && d8_at == 0) d8_at = sw_c;
            if (if2.mem_wr_en) w2++;
            if (if8.mem_wr_en) w8++;
        end
        if (ab_go) begin
            if (if4.mem_wr_en) ab_wr++;
            if (done4) ab_done++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_tile1;
        logic [7:0] f3_exp [10];
        f3_exp = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h08,
                   8'h0C, 8'h10, 8'h00, 8'h00, 8'h00};
        chk("lit_w_first", 64'(addr_log[2]), 64'h100);
        chk("lit_w_last", 64'(addr_log[5]), 64'h103);
        chk("lit_i_first", 64'(addr_log[6]), 64'h200);
        chk("lit_i_last", 64'(addr_log[9]), 64'h203);
        chk("lit_ce_pre", 64'(ce_log[9]), 64'h0);
        chk("lit_ce_first", 64'(ce_log[10]), 64'h1);
        chk("lit_ce_last", 64'(ce_log[19]), 64'h1);
        chk("lit_ce_post", 64'(ce_log[20]), 64'h0);
        chk("lit_o_first", 64'(addr_log[20]), 64'h300);
        chk("lit_o_last", 64'(addr_log[23]), 64'h303);
        chk("lit_done24", 64'(done_log[24]), 64'h1);
        for (int t = 0; t < 10; t++)
            chk($sformatf("lit_skew_t%0d", t),
                64'(f3_log[t]), 64'(f3_exp[t]));
    endtask

    initial begin
        for (int a = 0; a < 1024; a++)
            rom[a] = {8'(a) ^ 8'h5A, 8'(a), ~8'(a), 8'(a) + 8'h11};
        rom[10'h200] = 32'h04030201;
        rom[10'h201] = 32'h08070605;
        rom[10'h202] = 32'h0C0B0A09;
        rom[10'h203] = 32'h100F0E0D;
        for (int i = 0; i < N; i++) psum4[i] = 32'hC0DE0000 + i;
        for (int i = 0; i < 2; i++) psum2[i] = 32'h22220000 + i;
        for (int i = 0; i < 8; i++) psum8[i] = 32'h88880000 + i;

        // reset, then idle with start low
        tick(3);
        nRST = 1'b1;
        tick(3);
        chk("lit_idle_busy", 64'(busy4), 64'h0);

        // full tile
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(26);
        check_tile1();

        // wrap, start held through DONE
        ib = 10'h3FE;
        op0 = 3'd7;
        op1 = 3'd1;
        start = 1'b1;
        tick(25);
        chk("lit_idle_after_done", 64'(busy4), 64'h0);
        tick(1);
        start = 1'b0;
        tick(26);
        chk("lit_wrap0", 64'(addr_log[6]), 64'h3FE);
        chk("lit_wrap1", 64'(addr_log[7]), 64'h3FF);
        chk("lit_wrap2", 64'(addr_log[8]), 64'h000);
        chk("lit_wrap3", 64'(addr_log[9]), 64'h001);

        // abort at COMPUTE t=5
        ib = 10'h200;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(14);
        clear = 1'b1;
        ab_go = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("lit_abort_idle", 64'(busy4), 64'h0);
        tick(6);
        ab_go = 1'b0;
        chk("lit_abort_wr", 64'(ab_wr), 64'h0);
        chk("lit_abort_done", 64'(ab_done), 64'h0);

        // tile after abort
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(26);
        check_tile1();

        // reset mid LD_INPUT
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(7);
        #2 nRST = 1'b0;
        tick(2);
        nRST = 1'b1;
        tick(4);
        chk("lit_rst_busy", 64'(busy4), 64'h0);

        // N=2 / N=8 sweep
        start_sw = 1'b1;
        tick(1);
        start_sw = 1'b0;
        sw_go = 1'b1;
        tick(60);
        sw_go = 1'b0;
        chk("sweep2_done_at", 64'(d2_at), 64'd12);
        chk("sweep2_writes", 64'(w2), 64'd2);
        chk("sweep8_done_at", 64'(d8_at), 64'd48);
        chk("sweep8_writes", 64'(w8), 64'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
